// File: rtl/dither_rgb_scheduler.sv
// Error-diffusion dither: 24-bit RGB in, 12-bit RGB out. One shared quantizer
// is time-multiplexed over R, G and B by a five-state FSM.
module dither_rgb_scheduler #(
  parameter int unsigned THRESHOLD     = 8,
  parameter bit          DITHER_EN_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        visible,
  input  logic        dither_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_rgb,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, OUT} state_t;

  state_t             state_q, state_d;
  logic [23:0]        pix_q, pix_d;
  logic               den_q, den_d;
  logic signed [5:0]  err_r_q, err_r_d;
  logic signed [5:0]  err_g_q, err_g_d;
  logic signed [5:0]  err_b_q, err_b_d;
  logic [11:0]        out_rgb_q, out_rgb_d;

  logic [7:0]         ch_pix;
  logic signed [5:0]  ch_err;
  logic signed [5:0]  err_use;
  logic signed [9:0]  sum;
  logic [7:0]         sat;
  logic [3:0]         qn;
  logic signed [5:0]  err_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      den_q     <= DITHER_EN_RST;
      err_r_q   <= '0;
      err_g_q   <= '0;
      err_b_q   <= '0;
      out_rgb_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      den_q     <= den_d;
      err_r_q   <= err_r_d;
      err_g_q   <= err_g_d;
      err_b_q   <= err_b_d;
      out_rgb_q <= out_rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CH_R;
      CH_R:    state_d = CH_G;
      CH_G:    state_d = CH_B;
      CH_B:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared quantizer: operand mux by state, then add/clamp/round.
  always_comb begin
    ch_pix = '0;
    ch_err = '0;
    unique case (state_q)
      CH_R:    begin ch_pix = pix_q[23:16]; ch_err = err_r_q; end
      CH_G:    begin ch_pix = pix_q[15:8];  ch_err = err_g_q; end
      CH_B:    begin ch_pix = pix_q[7:0];   ch_err = err_b_q; end
      default: begin ch_pix = '0;           ch_err = '0;      end
    endcase
    err_use = (den_q && visible) ? ch_err : '0;
    sum = signed'({2'b00, ch_pix}) + signed'({{4{err_use[5]}}, err_use});
    if (sum < 0)
      sat = '0;
    else if (sum > 10'sd255)
      sat = '1;
    else
      sat = sum[7:0];
    if (({1'b0, sat[3:0]} >= 5'(THRESHOLD)) && (sat[7:4] != 4'hF))
      qn = sat[7:4] + 4'd1;
    else
      qn = sat[7:4];
    // Residual lies in -8..15, so the low six bits of sat - 16*qn are exact.
    err_new = den_q ? signed'(sat[5:0] - {qn[1:0], 4'b0000}) : '0;
  end

  always_comb begin
    pix_d     = pix_q;
    den_d     = den_q;
    err_r_d   = err_r_q;
    err_g_d   = err_g_q;
    err_b_d   = err_b_q;
    out_rgb_d = out_rgb_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        pix_d = in_rgb;
        den_d = dither_en;
      end
      CH_R: begin err_r_d = err_new; out_rgb_d[11:8] = qn; end
      CH_G: begin err_g_d = err_new; out_rgb_d[7:4]  = qn; end
      CH_B: begin err_b_d = err_new; out_rgb_d[3:0]  = qn; end
      default: ;
    endcase
    // Blanking wins over any same-cycle channel update.
    if (!visible) begin
      err_r_d = '0;
      err_g_d = '0;
      err_b_d = '0;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    out_rgb   = out_rgb_q;
  end

endmodule

// File: tb/tb_dither_rgb_scheduler.sv
// Directed bench for dither_rgb_scheduler: reset, error carry, clamping,
// blanking, backpressure, bypass and mid-flight reset.
module tb_dither_rgb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        visible;
  logic        dither_en;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_rgb;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  dither_rgb_scheduler #(.THRESHOLD(8), .DITHER_EN_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .visible(visible), .dither_en(dither_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input int er, input int eg, input int eb);
    check({tag, "_err_r"}, 32'(dut.err_r_q), 32'(er));
    check({tag, "_err_g"}, 32'(dut.err_g_q), 32'(eg));
    check({tag, "_err_b"}, 32'(dut.err_b_q), 32'(eb));
  endtask

  // Accept one pixel, check 4-cycle latency and value; consume if out_ready.
  task automatic send(input string tag, input logic [23:0] rgb, input logic [11:0] exp);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_rgb   = rgb;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_rgb"}, 32'(out_rgb), 32'(exp));
    if (out_ready) tick();
  endtask

  initial begin
    rst       = 1'b1;
    visible   = 1'b1;
    dither_en = 1'b1;
    in_valid  = 1'b1;
    in_rgb    = 24'h123456;
    out_ready = 1'b1;

    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    check("rst_out_rgb", 32'(out_rgb), 32'h000);
    check("rst_out_valid2", 32'(out_valid), 32'd0);
    check_err("rst", 0, 0, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    send("carry1", 24'h474747, 12'h444);
    check_err("carry1", 7, 7, 7);
    send("carry2", 24'h474747, 12'h555);
    check_err("carry2", -2, -2, -2);

    send("negclamp", 24'h000000, 12'h000);
    check_err("negclamp", 0, 0, 0);

    send("sat1", 24'hFF0000, 12'hF00);
    check_err("sat1", 15, 0, 0);
    send("sat2", 24'hFF0000, 12'hF00);
    check_err("sat2", 15, 0, 0);
    send("sat_carry", 24'h000000, 12'h100);
    check_err("sat_carry", -1, 0, 0);

    send("preblank", 24'h474747, 12'h444);
    check_err("preblank", 6, 7, 7);
    visible = 1'b0;
    tick();
    visible = 1'b1;
    check_err("blank", 0, 0, 0);
    send("postblank", 24'h474747, 12'h444);
    check_err("postblank", 7, 7, 7);

    out_ready = 1'b0;
    send("bp", 24'h101010, 12'h111);
    in_valid = 1'b1;
    in_rgb   = 24'h474747;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_rgb", 32'(out_rgb), 32'h111);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    send("bp_next", 24'h474747, 12'h555);
    check_err("bp_next", -2, -2, -2);

    dither_en = 1'b0;
    send("bypass", 24'h4E4E4E, 12'h555);
    check_err("bypass", 0, 0, 0);
    dither_en = 1'b1;

    in_valid = 1'b1;
    in_rgb   = 24'h474747;
    tick();
    in_valid = 1'b0;
    check("mid_busy_ch_r", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_out_valid", 32'(out_valid), 32'd0);
      check("mid_idle_busy", 32'(busy), 32'd0);
    end
    check_err("mid", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
